// File: rtl/dcache_fill.sv
// dcache line-refill engine: one BEATS x DATA_W burst read per request, beats written to the data RAM, then tag/valid/dirty.
// Latency: accept at T, ar_valid from T+1; zero-wait bus gives done at T+10 and ready again at T+11.
// Backpressure: ready only in IDLE, busy requests are neither accepted nor queued; ar_valid holds until ar_ready; r_ready is high throughout DATA.
// Optional: DCACHE_FILL_ERR_EN adds a sticky bus-error flag that reports through fill2ctrl_err and blocks the valid bit.
module dcache_fill #(
  parameter int TAG_W   = 44,
  parameter int INDEX_W = 6,
  parameter int WAY_W   = 3,
  parameter int DATA_W  = 64,
  parameter int BEATS   = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   ctrl2fill_valid,
  input  logic [INDEX_W-1:0]                     ctrl2fill_index,
  input  logic [WAY_W-1:0]                       ctrl2fill_way,
  input  logic [TAG_W-1:0]                       ctrl2fill_tag,
  output logic                                   fill2ctrl_ready,
  output logic                                   fill2ctrl_done,
  output logic                                   ar_valid,
  input  logic                                   ar_ready,
  output logic [TAG_W+INDEX_W+6-1:0]             ar_addr,
  output logic [7:0]                             ar_len,
  input  logic                                   r_valid,
  output logic                                   r_ready,
  input  logic [DATA_W-1:0]                      r_data,
  input  logic                                   r_last,
  input  logic [1:0]                             r_resp,
  output logic                                   fill2data_we,
  output logic [INDEX_W-1:0]                     fill2data_index,
  output logic [WAY_W-1:0]                       fill2data_way,
  output logic [((BEATS>1)?$clog2(BEATS):1)-1:0] fill2data_beat,
  output logic [DATA_W-1:0]                      fill2data_wdata,
  output logic                                   fill2tag_we,
  output logic [INDEX_W-1:0]                     fill2tag_index,
  output logic [WAY_W-1:0]                       fill2tag_way,
  output logic [TAG_W-1:0]                       fill2tag_tag,
  output logic                                   fill2tag_valid,
  output logic                                   fill2tag_dirty,
  output logic                                   fill2ctrl_err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    TAG  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [INDEX_W-1:0] index_q;
  logic [WAY_W-1:0]   way_q;
  logic [TAG_W-1:0]   tag_q;

  logic accept;
  logic beat_acc;
  logic last_beat;
  logic err_flag;

  assign accept    = (state == IDLE) && ctrl2fill_valid;
  assign beat_acc  = (state == DATA) && r_valid;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // Main fill sequencer: latch the request, hand the address to the bus, count beats, then one tag-write cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      index_q  <= '0;
      way_q    <= '0;
      tag_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl2fill_valid) begin
            index_q  <= ctrl2fill_index;
            way_q    <= ctrl2fill_way;
            tag_q    <= ctrl2fill_tag;
            beat_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ar_ready) begin
            state <= DATA;
          end
        end
        DATA: begin
          // Completion is purely by beat count; the counter wraps to 0 on the final beat.
          if (r_valid) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (last_beat) begin
              state <= TAG;
            end
          end
        end
        TAG: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_FILL_ERR_EN
  logic err_q;

  // Sticky bus-error flag: a bad response or an r_last that disagrees with our own beat count poisons the line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (beat_acc && ((r_resp != 2'b00) || (r_last != last_beat))) begin
      err_q <= 1'b1;
    end
  end

  assign err_flag = err_q;
`else
  // Without the error option the bus status inputs carry no meaning for this engine.
  logic unused_bus_status;
  assign unused_bus_status = ^{r_last, r_resp, accept};
  assign err_flag          = 1'b0;
`endif

  // Controller handshake and completion decode from the state register.
  assign fill2ctrl_ready = (state == IDLE);
  assign fill2ctrl_done  = (state == TAG);
  assign fill2ctrl_err   = (state == TAG) && err_flag;

  // Read address channel: address comes from latched fields so it stays stable while ar_ready is low.
  assign ar_valid = (state == REQ);
  assign ar_addr  = {tag_q, index_q, 6'b0};
  assign ar_len   = 8'(BEATS - 1);

  // Read data channel: each accepted beat goes straight into the data RAM in the same cycle.
  assign r_ready         = (state == DATA);
  assign fill2data_we    = beat_acc;
  assign fill2data_index = index_q;
  assign fill2data_way   = way_q;
  assign fill2data_beat  = beat_cnt;
  assign fill2data_wdata = beat_acc ? r_data : '0;

  // Tag RAM update: a new line is always clean; it is valid unless the bus reported an error.
  assign fill2tag_we    = (state == TAG);
  assign fill2tag_index = index_q;
  assign fill2tag_way   = way_q;
  assign fill2tag_tag   = tag_q;
  assign fill2tag_valid = (state == TAG) && !err_flag;
  assign fill2tag_dirty = 1'b0;

endmodule

// File: tb/tb_dcache_fill.sv
// Self-checking bench for dcache_fill: scoreboard of expected data/tag writes popped as the DUT writes them.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Build with +define+DCACHE_FILL_ERR_EN to check the bus-error option.
module tb_dcache_fill;

  localparam int BEATS = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl2fill_valid = 1'b0;
  logic [5:0]  ctrl2fill_index = '0;
  logic [2:0]  ctrl2fill_way = '0;
  logic [43:0] ctrl2fill_tag = '0;
  logic        fill2ctrl_ready, fill2ctrl_done;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [55:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_data = '0;
  logic        r_last = 1'b0;
  logic [1:0]  r_resp = '0;
  logic        fill2data_we;
  logic [5:0]  fill2data_index;
  logic [2:0]  fill2data_way;
  logic [2:0]  fill2data_beat;
  logic [63:0] fill2data_wdata;
  logic        fill2tag_we;
  logic [5:0]  fill2tag_index;
  logic [2:0]  fill2tag_way;
  logic [43:0] fill2tag_tag;
  logic        fill2tag_valid, fill2tag_dirty;
  logic        fill2ctrl_err;

  dcache_fill dut (
    .clock(clock), .reset(reset),
    .ctrl2fill_valid(ctrl2fill_valid), .ctrl2fill_index(ctrl2fill_index),
    .ctrl2fill_way(ctrl2fill_way), .ctrl2fill_tag(ctrl2fill_tag),
    .fill2ctrl_ready(fill2ctrl_ready), .fill2ctrl_done(fill2ctrl_done),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .fill2data_we(fill2data_we), .fill2data_index(fill2data_index), .fill2data_way(fill2data_way),
    .fill2data_beat(fill2data_beat), .fill2data_wdata(fill2data_wdata),
    .fill2tag_we(fill2tag_we), .fill2tag_index(fill2tag_index), .fill2tag_way(fill2tag_way),
    .fill2tag_tag(fill2tag_tag), .fill2tag_valid(fill2tag_valid), .fill2tag_dirty(fill2tag_dirty),
    .fill2ctrl_err(fill2ctrl_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  idx;
    logic [2:0]  way;
    logic [2:0]  beat;
    logic [63:0] data;
  } dexp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [2:0]  way;
    logic [43:0] tag;
    logic        valid;
    logic        err;
  } texp_t;

  dexp_t dq[$];
  texp_t tq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_done_exp = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected entry.
  always @(negedge clock) begin
    if (fill2ctrl_done === 1'b1) n_done++;
    if (fill2data_we !== 1'b0) begin
      if (dq.size() == 0) begin
        chk("data_we_unexpected", 64'(fill2data_we), 64'd0);
      end else begin
        dexp_t e;
        e = dq.pop_front();
        chk("data_index", 64'(fill2data_index), 64'(e.idx));
        chk("data_way", 64'(fill2data_way), 64'(e.way));
        chk("data_beat", 64'(fill2data_beat), 64'(e.beat));
        chk("data_wdata", fill2data_wdata, e.data);
      end
    end
    if (fill2tag_we !== 1'b0) begin
      if (tq.size() == 0) begin
        chk("tag_we_unexpected", 64'(fill2tag_we), 64'd0);
      end else begin
        texp_t t;
        t = tq.pop_front();
        chk("tag_index", 64'(fill2tag_index), 64'(t.idx));
        chk("tag_way", 64'(fill2tag_way), 64'(t.way));
        chk("tag_tag", 64'(fill2tag_tag), 64'(t.tag));
        chk("tag_valid", 64'(fill2tag_valid), 64'(t.valid));
        chk("tag_dirty", 64'(fill2tag_dirty), 64'd0);
        chk("fill_err", 64'(fill2ctrl_err), 64'(t.err));
      end
    end
  end

  // One fill from an IDLE cycle: entered and left 1ns after a rising edge.
  task automatic do_fill(input logic [5:0] idx, input logic [2:0] way, input logic [43:0] tag,
                         input logic [63:0] base, input int ar_wait, input bit gaps,
                         input int err_beat, input bit hold, input int stop_beats, input bit chk_lat);
    int t_acc;
    int i;
    int k;
    bit rv;
    bit e_err;
    texp_t t;
    ctrl2fill_valid = 1'b1;
    ctrl2fill_index = idx;
    ctrl2fill_way   = way;
    ctrl2fill_tag   = tag;
    @(negedge clock);
    chk("idle_ready", 64'(fill2ctrl_ready), 64'd1);
    chk("idle_done", 64'(fill2ctrl_done), 64'd0);
    t_acc = cyc;
    @(posedge clock); #1;
    // Scramble request fields while busy: only the accepted values may be used.
    ctrl2fill_valid = hold;
    ctrl2fill_index = 6'($urandom);
    ctrl2fill_way   = 3'($urandom);
    ctrl2fill_tag   = 44'({$urandom, $urandom});
    for (int w = 0; w <= ar_wait; w++) begin
      ar_ready = (w == ar_wait);
      @(negedge clock);
      chk("req_ar_valid", 64'(ar_valid), 64'd1);
      chk("req_ar_addr", 64'(ar_addr), 64'({tag, idx, 6'b0}));
      chk("req_ar_len", 64'(ar_len), 64'(BEATS - 1));
      chk("req_ready", 64'(fill2ctrl_ready), 64'd0);
      chk("req_r_ready", 64'(r_ready), 64'd0);
      @(posedge clock); #1;
    end
    ar_ready = 1'b0;
    i = 0;
    k = 0;
    while (i < stop_beats) begin
      rv = !(gaps && k[0]);
      r_valid = rv;
      r_data  = base + 64'(i);
      r_last  = (i == BEATS - 1);
      r_resp  = (i == err_beat) ? 2'b10 : 2'b00;
      if (rv) dq.push_back('{idx: idx, way: way, beat: 3'(i), data: base + 64'(i)});
      @(negedge clock);
      chk("data_r_ready", 64'(r_ready), 64'd1);
      chk("data_ar_valid", 64'(ar_valid), 64'd0);
      chk("data_done", 64'(fill2ctrl_done), 64'd0);
      chk("data_ready", 64'(fill2ctrl_ready), 64'd0);
      @(posedge clock); #1;
      if (rv) i++;
      k++;
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
    if (stop_beats < BEATS) return;
`ifdef DCACHE_FILL_ERR_EN
    e_err = (err_beat < BEATS);
`else
    e_err = 1'b0;
`endif
    t = '{idx: idx, way: way, tag: tag, valid: !e_err, err: e_err};
    tq.push_back(t);
    n_done_exp++;
    @(negedge clock);
    chk("tag_done", 64'(fill2ctrl_done), 64'd1);
    chk("tag_r_ready", 64'(r_ready), 64'd0);
    if (chk_lat) chk("done_latency", 64'(cyc - t_acc), 64'd10);
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_ready", 64'(fill2ctrl_ready), 64'd1);
    chk("rst_done", 64'(fill2ctrl_done), 64'd0);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_ar_addr", 64'(ar_addr), 64'd0);
    chk("rst_ar_len", 64'(ar_len), 64'd7);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_data_we", 64'(fill2data_we), 64'd0);
    chk("rst_data_beat", 64'(fill2data_beat), 64'd0);
    chk("rst_data_index", 64'(fill2data_index), 64'd0);
    chk("rst_tag_we", 64'(fill2tag_we), 64'd0);
    chk("rst_tag_valid", 64'(fill2tag_valid), 64'd0);
    chk("rst_err", 64'(fill2ctrl_err), 64'd0);
    @(posedge clock); #1;

    // Zero-wait bus, fixed pattern, latency check.
    do_fill(6'h15, 3'd3, 44'hABC, 64'h1000, 0, 1'b0, 99, 1'b0, BEATS, 1'b1);
    // Address stall and gapped data.
    do_fill(6'h2A, 3'd6, 44'h123456789AB, 64'hDEAD_0000, 5, 1'b1, 99, 1'b0, BEATS, 1'b0);
    // Request held high through a fill, then back-to-back second fill.
    do_fill(6'h01, 3'd7, 44'hFFFFFFFFFFF, 64'hAAAA_0000_0000_0000, 0, 1'b0, 99, 1'b1, BEATS, 1'b1);
    do_fill(6'h3F, 3'd0, 44'h00000000001, 64'h5555_0000, 2, 1'b0, 99, 1'b0, BEATS, 1'b0);

    // Reset after beat 3 is accepted: no tag write, no done, engine idle.
    do_fill(6'h0C, 3'd2, 44'h777, 64'h9000, 0, 1'b0, 99, 1'b0, 4, 1'b0);
    reset   = 1'b0;
    r_valid = 1'b1;
    @(negedge clock);
    chk("abort_ready", 64'(fill2ctrl_ready), 64'd1);
    chk("abort_done", 64'(fill2ctrl_done), 64'd0);
    chk("abort_tag_we", 64'(fill2tag_we), 64'd0);
    chk("abort_r_ready", 64'(r_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("idle_r_ready", 64'(r_ready), 64'd0);
    chk("idle_data_we", 64'(fill2data_we), 64'd0);
    chk("idle_tag_we", 64'(fill2tag_we), 64'd0);
    @(posedge clock); #1;
    r_valid = 1'b0;

    // Error response on beat 5, then a clean fill.
    do_fill(6'h22, 3'd5, 44'hBAD, 64'hE000, 1, 1'b0, 5, 1'b0, BEATS, 1'b0);
    do_fill(6'h23, 3'd4, 44'hC1EA, 64'hF000, 0, 1'b0, 99, 1'b0, BEATS, 1'b1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("end_ready", 64'(fill2ctrl_ready), 64'd1);
    chk("data_queue_left", 64'(dq.size()), 64'd0);
    chk("tag_queue_left", 64'(tq.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_done_exp));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_fill.md
Name: dcache_fill

Overview:
- Line-refill engine directly downstream of the dcache controller's fill request (ctrl2fill_valid/index/way/tag, fill2ctrl_ready).
- Issues one 8-beat x 64-bit burst read on the memory bus for the 64-byte line {tag, index, 6'b0}.
- Writes each returned beat into the selected way of the data RAM, then writes tag/valid/dirty for that way.
- Reports completion back to the controller.

Parameters:
TAG_W, 44, physical tag width
INDEX_W, 6, set index width
WAY_W, 3, way select width (8 ways)
DATA_W, 64, bus/data RAM beat width
BEATS, 8, beats per line; power of two; beat counter is log2(BEATS) bits

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
ctrl2fill_valid  in  1  refill request
ctrl2fill_index  in  INDEX_W  set to refill
ctrl2fill_way  in  WAY_W  way to refill
ctrl2fill_tag  in  TAG_W  physical tag of line
fill2ctrl_ready  out  1  engine idle, request accepted when valid&ready
fill2ctrl_done  out  1  one-cycle pulse, line and tag written
ar_valid  out  1  bus read address valid
ar_ready  in  1  bus read address ready
ar_addr  out  TAG_W+INDEX_W+6  line address {tag,index,6'b0}
ar_len  out  8  constant BEATS-1
r_valid  in  1  read data valid
r_ready  out  1  read data ready
r_data  in  DATA_W  read data beat
r_last  in  1  last beat marker
r_resp  in  2  beat response, 2'b00 = OKAY
fill2data_we  out  1  data RAM write enable
fill2data_index  out  INDEX_W  data RAM set
fill2data_way  out  WAY_W  data RAM way
fill2data_beat  out  log2(BEATS)  beat slot within line
fill2data_wdata  out  DATA_W  beat data
fill2tag_we  out  1  tag RAM write enable
fill2tag_index  out  INDEX_W  tag RAM set
fill2tag_way  out  WAY_W  tag RAM way
fill2tag_tag  out  TAG_W  tag written
fill2tag_valid  out  1  valid bit written
fill2tag_dirty  out  1  dirty bit written, always 0
fill2ctrl_err  out  1  bus error on this fill, meaningful with done; only driven when DCACHE_FILL_ERR_EN defined, else tied 0

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset: state = IDLE, beat counter = 0, latched index/way/tag = 0.
  - Outputs at reset: fill2ctrl_ready = 1; ar_addr = 0; ar_len = BEATS-1.
  - All other outputs 0.
- States: IDLE, REQ, DATA, TAG.
- IDLE:
  - fill2ctrl_ready = 1.
  - On ctrl2fill_valid: latch index/way/tag, clear beat counter, go to REQ next cycle.
- REQ:
  - ar_valid = 1; ar_addr = {tag_q, index_q, 6'b0} held stable until handshake.
  - On ar_ready: go to DATA. ar_valid never drops before ar_ready.
- DATA:
  - r_ready = 1.
  - Each r_valid cycle:
    - fill2data_we = 1 combinationally in the same cycle.
    - fill2data_beat = counter; fill2data_wdata = r_data.
    - Counter increments.
  - On the accepted beat with counter == BEATS-1: go to TAG. Counter wraps to 0.
  - r_valid low: no write, counter holds.
- TAG (exactly 1 cycle):
  - fill2tag_we = 1; fill2tag_tag = tag_q; fill2tag_valid = 1; fill2tag_dirty = 0.
  - fill2ctrl_done = 1.
  - Next state IDLE.
- fill2data_index/way and fill2tag_index/way = latched values in all states.
- Latency:
  - Accept at cycle T; ar_valid from T+1.
  - With zero-wait bus (ar_ready at T+1, beats T+2..T+9): done at T+10, ready again T+11.
- Busy: fill2ctrl_ready = 0 in REQ/DATA/TAG; requests there are not accepted and not queued.
- r_last and r_resp are ignored unless DCACHE_FILL_ERR_EN is defined. Completion is purely beat-count based.
- r_valid outside DATA is ignored (r_ready = 0).
- Reset mid-fill: immediate return to IDLE. Partial line data may remain in the data RAM, but no tag write occurs, so the way is never marked valid.

Optional Feature:
DCACHE_FILL_ERR_EN
- Defined:
  - Sticky err flag is set by any of:
    - r_resp != 0 on an accepted beat;
    - r_last = 1 on a non-final beat;
    - r_last = 0 on the final beat.
  - In TAG: fill2tag_valid = ~err; fill2ctrl_err = err alongside done.
  - err is cleared on request accept.
  - Data beats are still written.
- Not defined: fill2ctrl_err tied 0, fill2tag_valid always 1, no flag logic.

Test Plan:
- Reset (reset=0) then release, no request -> ready=1, all other outputs 0, state IDLE.
- Request index=6'h15, way=3, tag=44'hABC, zero-wait bus, data 0x1000+i -> ar_addr={44'hABC,6'h15,6'h0}, ar_len=7, 8 writes beat 0..7 with 0x1000..0x1007, tag write valid=1 dirty=0, done at T+10.
- ar_ready low for 5 cycles, r_valid toggling every other cycle -> ar_addr stable, no data write while r_valid=0, beats still 0..7 in order, single done.
- ctrl2fill_valid held high throughout a fill -> no second accept until cycle after done; second fill starts cleanly with counter 0.
- reset asserted after beat 3 -> next cycle IDLE, ready=1, no tag write, no done.
- (ERR_EN) r_resp=2'b10 on beat 5 -> all 8 beats written, tag write valid=0, err=1 with done; next clean fill gives err=0.
